// File: rtl/vector_split.sv
// ---------------------------------------------------------------------------
// vector_split
//   De-interleaves one stream read from an upstream first-word-fall-through
//   FIFO into two downstream FIFOs.  Even-numbered words (0,2,4,...) go to X
//   and odd-numbered words (1,3,5,...) go to Y.  Each word is fetched into a
//   holding register, then written to the lane currently selected.  With no
//   backpressure this gives one word every two cycles.
//
//   Optional feature: define VECTOR_SPLIT_STATS_EN to add the 32-bit write
//   counters x_count / y_count.  Both wrap from 0xFFFFFFFF to 0.
//
// Ports
//   clock     in   single clock, all state updates on its rising edge
//   reset     in   synchronous, active-high reset
//   in_dout   in   upstream FIFO head word (valid while in_empty=0)
//   in_empty  in   upstream FIFO holds no word
//   in_rd_en  out  pop the upstream head word at the next rising edge
//   x_din     out  X FIFO write data (always the holding register)
//   x_wr_en   out  X FIFO write strobe
//   x_full    in   X FIFO cannot accept a word
//   y_din     out  Y FIFO write data (always the holding register)
//   y_wr_en   out  Y FIFO write strobe
//   y_full    in   Y FIFO cannot accept a word
//   x_count   out  (VECTOR_SPLIT_STATS_EN only) number of X writes
//   y_count   out  (VECTOR_SPLIT_STATS_EN only) number of Y writes
// ---------------------------------------------------------------------------
module vector_split #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic                  x_wr_en,
  input  logic                  x_full,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic                  y_wr_en,
  input  logic                  y_full
`ifdef VECTOR_SPLIT_STATS_EN
  ,
  output logic [31:0]           x_count,
  output logic [31:0]           y_count
`endif
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam logic LANE_X = 1'b0;
  localparam logic LANE_Y = 1'b1;

  state_t                  state_q, state_d;
  logic                    lane_q,  lane_d;
  logic [DATA_WIDTH-1:0]   hold_q,  hold_d;

  // The word currently selected for output can be written this cycle.
  logic lane_ready;
  assign lane_ready = (lane_q == LANE_X) ? !x_full : !y_full;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its _d; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      lane_q  <= LANE_X;
      // NOTE: the holding register is a single word, not a memory, and it is
      // cleared so x_din/y_din read 0 after reset and a held word is dropped.
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which is what would otherwise infer a latch.
    state_d = state_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    case (state_q)
      S_FETCH: begin
        if (!in_empty) begin
          hold_d  = in_dout;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Only the selected lane may advance; a free opposite lane is ignored
        // so ordering across X and Y is preserved.
        if (lane_ready) begin
          lane_d  = ~lane_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: strobes are purely combinational and gated off in reset so
  // a reset cycle can never pop or push a word.
  // -------------------------------------------------------------------------
  always_comb begin
    in_rd_en = 1'b0;
    x_wr_en  = 1'b0;
    y_wr_en  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: in_rd_en = !in_empty;
        S_WRITE: begin
          if (lane_q == LANE_X) x_wr_en = !x_full;
          else                  y_wr_en = !y_full;
        end
        default: ;
      endcase
    end
  end

  assign x_din = hold_q;
  assign y_din = hold_q;

`ifdef VECTOR_SPLIT_STATS_EN
  // -------------------------------------------------------------------------
  // Write counters; natural 32-bit overflow gives the wrap to zero.
  // -------------------------------------------------------------------------
  logic [31:0] x_count_q, x_count_d;
  logic [31:0] y_count_q, y_count_d;

  always_comb begin
    x_count_d = x_count_q + (x_wr_en ? 32'd1 : 32'd0);
    y_count_d = y_count_q + (y_wr_en ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_count_q <= '0;
      y_count_q <= '0;
    end else begin
      x_count_q <= x_count_d;
      y_count_q <= y_count_d;
    end
  end

  assign x_count = x_count_q;
  assign y_count = y_count_q;
`endif

endmodule

// File: tb/tb_vector_split.sv
// ---------------------------------------------------------------------------
// tb_vector_split
//   Scoreboard bench for vector_split.  Directed stimulus pushes words into a
//   model of the upstream FIFO and the hand-derived X/Y words into expectation
//   queues; a monitor pops and compares on every write strobe.
// ---------------------------------------------------------------------------
module tb_vector_split;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_dout = '0;
  logic          in_empty = 1'b1;
  logic          in_rd_en;
  logic [DW-1:0] x_din, y_din;
  logic          x_wr_en, y_wr_en;
  logic          x_full = 1'b0;
  logic          y_full = 1'b0;
`ifdef VECTOR_SPLIT_STATS_EN
  logic [31:0]   x_count, y_count;
`endif

  vector_split #(.DATA_WIDTH(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_dout  (in_dout),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .x_din    (x_din),
    .x_wr_en  (x_wr_en),
    .x_full   (x_full),
    .y_din    (y_din),
    .y_wr_en  (y_wr_en),
    .y_full   (y_full)
`ifdef VECTOR_SPLIT_STATS_EN
    ,
    .x_count  (x_count),
    .y_count  (y_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] src_q[$];     // upstream FIFO contents
  logic [DW-1:0] x_exp_q[$];
  logic [DW-1:0] y_exp_q[$];
  int            wr_cycles[$];
  int            rd_cycles[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream FWFT FIFO model: pop on an edge where in_rd_en was high.
  initial begin : feeder
    logic do_pop;
    forever begin
      @(negedge clock);
      do_pop = in_rd_en;
      @(posedge clock);
      #1;
      if (do_pop && src_q.size() > 0) void'(src_q.pop_front());
      in_empty = (src_q.size() == 0);
      in_dout  = (src_q.size() == 0) ? '0 : src_q[0];
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (in_rd_en) rd_cycles.push_back(cyc);
      if (x_wr_en || y_wr_en) begin
        wr_cycles.push_back(cyc);
        check("wr_en_exclusive", {31'd0, x_wr_en & y_wr_en}, 32'd0);
        check("rd_en_in_write", {31'd0, in_rd_en}, 32'd0);
      end
      if (x_wr_en) begin
        if (x_exp_q.size() == 0) check("x_spurious_write", {31'd0, x_wr_en}, 32'd0);
        else check("x_data", x_din, x_exp_q.pop_front());
      end
      if (y_wr_en) begin
        if (y_exp_q.size() == 0) check("y_spurious_write", {31'd0, y_wr_en}, 32'd0);
        else check("y_data", y_din, y_exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (x_exp_q.size() == 0 && y_exp_q.size() == 0 && src_q.size() == 0) break;
      tick(1);
    end
    tick(3);
    check({"drain_", name}, x_exp_q.size() + y_exp_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic any_en;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;

    // Idle after reset: no strobes, outputs zero.
    any_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      any_en = any_en | in_rd_en | x_wr_en | y_wr_en;
      if (x_din != '0 || y_din != '0) any_en = 1'b1;
    end
    check("idle_strobes_and_din", {31'd0, any_en}, 32'd0);
    check("reset_x_din", x_din, 32'd0);
    check("reset_y_din", y_din, 32'd0);

    // 1..6, no backpressure: X=1,3,5  Y=2,4,6, one write every 2 cycles.
    tick(1);
    wr_cycles.delete();
    rd_cycles.delete();
    for (int i = 1; i <= 6; i++) src_q.push_back(i);
    x_exp_q.push_back(1); x_exp_q.push_back(3); x_exp_q.push_back(5);
    y_exp_q.push_back(2); y_exp_q.push_back(4); y_exp_q.push_back(6);
    wait_drain("basic");
    check("basic_write_count", wr_cycles.size(), 32'd6);
    if (wr_cycles.size() == 6 && rd_cycles.size() >= 1) begin
      check("basic_latency", wr_cycles[0] - rd_cycles[0], 32'd1);
      for (int i = 1; i < 6; i++)
        check("basic_throughput", wr_cycles[i] - wr_cycles[i-1], 32'd2);
    end

    // X stalled: 0xA held with no write for 5 cycles, then X=0xA, Y=0xB.
    x_full = 1'b1;
    wr_cycles.delete();
    src_q.push_back(32'hA); src_q.push_back(32'hB);
    x_exp_q.push_back(32'hA);
    y_exp_q.push_back(32'hB);
    tick(3);
    tick(5);
    check("stall_hold_x_din", x_din, 32'hA);
    check("stall_no_write", wr_cycles.size(), 32'd0);
    x_full = 1'b0;
    wait_drain("stall");
    check("stall_write_count", wr_cycles.size(), 32'd2);

    // 7,8,9, idle gap, then 10: lane persists across the gap.
    src_q.push_back(7); src_q.push_back(8); src_q.push_back(9);
    x_exp_q.push_back(7); x_exp_q.push_back(9);
    y_exp_q.push_back(8);
    wait_drain("gap_first");
    tick(10);
    src_q.push_back(10);
    y_exp_q.push_back(10);
    wait_drain("gap_second");

    // Reset in S_WRITE holding 0x55: the word is discarded; 0x66 goes to X.
    x_full = 1'b1;
    src_q.push_back(32'h55);
    tick(4);
    check("held_55", x_din, 32'h55);
    @(posedge clock); #2;
    reset  = 1'b1;
    x_full = 1'b0;
    @(negedge clock);
    check("reset_forces_x_wr_en", {31'd0, x_wr_en}, 32'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    check("post_reset_x_din", x_din, 32'd0);
    check("post_reset_y_din", y_din, 32'd0);
    src_q.push_back(32'h66);
    x_exp_q.push_back(32'h66);
    wait_drain("after_reset");

    // 9 words after reset: X gets 5, Y gets 4.
    do_reset();
    wr_cycles.delete();
    for (int i = 0; i < 9; i++) begin
      src_q.push_back(32'h101 + i);
      if (i % 2 == 0) x_exp_q.push_back(32'h101 + i);
      else            y_exp_q.push_back(32'h101 + i);
    end
    wait_drain("nine");
    check("nine_write_count", wr_cycles.size(), 32'd9);
`ifdef VECTOR_SPLIT_STATS_EN
    check("x_count_nine", x_count, 32'd5);
    check("y_count_nine", y_count, 32'd4);
    do_reset();
    check("x_count_reset", x_count, 32'd0);
    check("y_count_reset", y_count, 32'd0);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
